// File: rtl/mem_ctrl.sv
// Byte-serial owner of the RAM/IO port: latches fetch, load and store
// requests, arbitrates store > load > fetch, assembles little-endian data.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_ce,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_ce,
  output logic [31:0] out_fetcher_data,
  input  logic        in_lsb_ce,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_address,
  output logic        out_lsb_ce,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_ce,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_address,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_ce,
  input  logic        in_rob_misbranch,
  input  logic        in_io_buffer_full,
  input  logic [7:0]  in_ram_din,
  output logic [7:0]  out_ram_dout,
  output logic [31:0] out_ram_a,
  output logic        out_ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic        cur_f_q, cur_f_d;
  logic        pend_f_q, pend_f_d;
  logic        pend_l_q, pend_l_d;
  logic        pend_s_q, pend_s_d;
  logic [31:0] f_addr_q, f_addr_d;
  logic [31:0] l_addr_q, l_addr_d;
  logic [2:0]  l_size_q, l_size_d;
  logic        l_sgn_q, l_sgn_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [2:0]  s_size_q, s_size_d;
  logic [31:0] s_data_q, s_data_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        fce_d, lce_d, rce_d;
  logic [31:0] fdata_d, ldata_d;
  logic [31:0] asm_w, ext_w;
  logic        grant_s, grant_l, grant_f;
  logic        unused_size;

  assign unused_size = ^{in_lsb_size[5:3], in_rob_size[5:3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      n_q              <= '0;
      base_q           <= '0;
      cur_f_q          <= 1'b0;
      pend_f_q         <= 1'b0;
      pend_l_q         <= 1'b0;
      pend_s_q         <= 1'b0;
      f_addr_q         <= '0;
      l_addr_q         <= '0;
      l_size_q         <= '0;
      l_sgn_q          <= 1'b0;
      s_addr_q         <= '0;
      s_size_q         <= '0;
      s_data_q         <= '0;
      rbuf_q           <= '0;
      out_fetcher_ce   <= 1'b0;
      out_lsb_ce       <= 1'b0;
      out_rob_ce       <= 1'b0;
      out_fetcher_data <= '0;
      out_lsb_data     <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      n_q              <= n_d;
      base_q           <= base_d;
      cur_f_q          <= cur_f_d;
      pend_f_q         <= pend_f_d;
      pend_l_q         <= pend_l_d;
      pend_s_q         <= pend_s_d;
      f_addr_q         <= f_addr_d;
      l_addr_q         <= l_addr_d;
      l_size_q         <= l_size_d;
      l_sgn_q          <= l_sgn_d;
      s_addr_q         <= s_addr_d;
      s_size_q         <= s_size_d;
      s_data_q         <= s_data_d;
      rbuf_q           <= rbuf_d;
      out_fetcher_ce   <= fce_d;
      out_lsb_ce       <= lce_d;
      out_rob_ce       <= rce_d;
      out_fetcher_data <= fdata_d;
      out_lsb_data     <= ldata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    base_d   = base_q;
    cur_f_d  = cur_f_q;
    pend_f_d = pend_f_q;
    pend_l_d = pend_l_q;
    pend_s_d = pend_s_q;
    f_addr_d = f_addr_q;
    l_addr_d = l_addr_q;
    l_size_d = l_size_q;
    l_sgn_d  = l_sgn_q;
    s_addr_d = s_addr_q;
    s_size_d = s_size_q;
    s_data_d = s_data_q;
    rbuf_d   = rbuf_q;
    fce_d    = 1'b0;
    lce_d    = 1'b0;
    rce_d    = 1'b0;
    fdata_d  = out_fetcher_data;
    ldata_d  = out_lsb_data;
    out_ram_a    = '0;
    out_ram_dout = '0;
    out_ram_wr   = 1'b0;

    asm_w = rbuf_q;
    asm_w[{k_q[1:0], 3'b000} +: 8] = in_ram_din;
    ext_w = asm_w;
    if (n_q == 3'd1)
      ext_w = {{24{l_sgn_q & asm_w[7]}}, asm_w[7:0]};
    else if (n_q == 3'd2)
      ext_w = {{16{l_sgn_q & asm_w[15]}}, asm_w[15:0]};

    grant_s = pend_s_q &&
              !((s_addr_q >= IO_BASE) && in_io_buffer_full);
    grant_l = pend_l_q && !in_rob_misbranch;
    grant_f = pend_f_q && !in_rob_misbranch;

    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (grant_s) begin
            state_d      = WRITE;
            base_d       = s_addr_q;
            n_d          = s_size_q;
            k_d          = 3'd1;
            out_ram_a    = s_addr_q;
            out_ram_dout = s_data_q[7:0];
            out_ram_wr   = 1'b1;
          end else if (grant_l) begin
            state_d   = READ;
            base_d    = l_addr_q;
            n_d       = l_size_q;
            cur_f_d   = 1'b0;
            k_d       = 3'd0;
            out_ram_a = l_addr_q;
          end else if (grant_f) begin
            state_d   = READ;
            base_d    = f_addr_q;
            n_d       = 3'd4;
            cur_f_d   = 1'b1;
            k_d       = 3'd0;
            out_ram_a = f_addr_q;
          end
        end
        READ: begin
          // address for the byte that arrives after the coming capture
          out_ram_a = base_q + 32'(k_q) + 32'd1;
          if (in_rob_misbranch) begin
            state_d = IDLE;
          end else begin
            rbuf_d = asm_w;
            k_d    = k_q + 3'd1;
            if (k_q + 3'd1 == n_q) begin
              state_d = IDLE;
              if (cur_f_q) begin
                fce_d    = 1'b1;
                fdata_d  = asm_w;
                pend_f_d = 1'b0;
              end else begin
                lce_d    = 1'b1;
                ldata_d  = ext_w;
                pend_l_d = 1'b0;
              end
            end
          end
        end
        WRITE: begin
          if (k_q == n_q) begin
            state_d  = IDLE;
            rce_d    = 1'b1;
            pend_s_d = 1'b0;
          end else begin
            out_ram_a    = base_q + 32'(k_q);
            out_ram_dout = s_data_q[{k_q[1:0], 3'b000} +: 8];
            out_ram_wr   = 1'b1;
            k_d          = k_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (in_rob_misbranch) begin
        pend_f_d = 1'b0;
        pend_l_d = 1'b0;
      end
      if (in_rob_ce) begin
        pend_s_d = 1'b1;
        s_addr_d = in_rob_address;
        s_size_d = in_rob_size[2:0];
        s_data_d = in_rob_data;
      end
      if (in_lsb_ce && !in_rob_misbranch) begin
        pend_l_d = 1'b1;
        l_addr_d = in_lsb_address;
        l_size_d = in_lsb_size[2:0];
        l_sgn_d  = in_lsb_signed;
      end
      if (in_fetcher_ce && !in_rob_misbranch) begin
        pend_f_d = 1'b1;
        f_addr_d = in_fetcher_addr;
      end
    end else if (state_q != IDLE) begin
      // frozen: hold the oldest byte not yet captured or written
      out_ram_a = base_q + 32'(k_q);
    end
  end

endmodule
